// File: rtl/tt3_pkg.sv
// Shared types for the 3-input truth-table blocks and their input conditioner.
package tt3_pkg;

  localparam int IN_W = 3;

  typedef logic [IN_W-1:0] tt3_vec_t;

endpackage

// File: rtl/tt3_input_conditioner_if.sv
// Change-event handshake: the conditioner drives valid/vector, the consumer drives ready.
interface tt3_input_conditioner_if;
  import tt3_pkg::*;

  logic     evt_valid_o;
  tt3_vec_t evt_vec_o;
  logic     evt_ready_i;

  modport master (
    output evt_valid_o,
    output evt_vec_o,
    input  evt_ready_i
  );

  modport slave (
    input  evt_valid_o,
    input  evt_vec_o,
    output evt_ready_i
  );

endinterface

// File: rtl/tt3_debounce_chan.sv
// One input channel: two-flop synchroniser, mismatch-run counter and the accepted stable level.
// o_upd is high in the cycle whose closing edge flips o_stable.
module tt3_debounce_chan #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_pin,
  output logic o_stable,
  output logic o_upd
);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_stable;
  logic [CNT_W-1:0] r_cnt;
  logic             w_diff;
  logic             w_upd;

  assign w_diff   = r_sync2 ^ r_stable;
  assign w_upd    = w_diff && (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1));
  assign o_stable = r_stable;
  assign o_upd    = w_upd;

  // synchroniser pair, then count consecutive mismatches; any agreeing sample restarts the run
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_stable <= 1'b0;
      r_cnt    <= {CNT_W{1'b0}};
    end else begin
      r_sync1 <= i_pin;
      r_sync2 <= r_sync1;
      if (w_upd) begin
        r_stable <= r_sync2;
        r_cnt    <= {CNT_W{1'b0}};
      end else if (w_diff) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end else begin
        r_cnt <= {CNT_W{1'b0}};
      end
    end
  end

endmodule

// File: rtl/tt3_input_conditioner.sv
// Debounced 3-pin front end with a single-entry, latest-wins change-event register.
// vec_o = {in1,in2,in3}; the event is loaded on the same edge that updates vec_o.
module tt3_input_conditioner
  import tt3_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 3,
  parameter int EVT_CNT_W       = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in1_i,
  input  logic                     in2_i,
  input  logic                     in3_i,
  output tt3_vec_t                 vec_o,
  tt3_input_conditioner_if.master  evt_if,
  output logic                     overrun_o,
  input  logic                     clr_overrun_i,
  output logic [EVT_CNT_W-1:0]     evt_cnt_o
);

  tt3_vec_t             w_pins;
  tt3_vec_t             w_stable;
  tt3_vec_t             w_upd;
  tt3_vec_t             w_new_vec;
  logic                 w_chg;
  logic                 w_accept;
  logic                 w_ovr_set;

  logic                 r_evt_valid;
  tt3_vec_t             r_evt_vec;
  logic                 r_overrun;
  logic [EVT_CNT_W-1:0] r_evt_cnt;

  assign w_pins = {in1_i, in2_i, in3_i};

  for (genvar g = 0; g < IN_W; g++) begin : g_chan
    tt3_debounce_chan #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_chan (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_pin    (w_pins[g]),
      .o_stable (w_stable[g]),
      .o_upd    (w_upd[g])
    );
  end

  // an updating channel always flips its bit, so the post-edge vector is a simple XOR
  assign w_new_vec = w_stable ^ w_upd;
  assign w_chg     = |w_upd;
  assign w_accept  = r_evt_valid && evt_if.evt_ready_i;
  assign w_ovr_set = w_chg && r_evt_valid && !evt_if.evt_ready_i;

  assign vec_o              = w_stable;
  assign evt_if.evt_valid_o = r_evt_valid;
  assign evt_if.evt_vec_o   = r_evt_vec;
  assign overrun_o          = r_overrun;
  assign evt_cnt_o          = r_evt_cnt;

  // event holding register, sticky overrun (set beats clear) and accepted-event counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_evt_valid <= 1'b0;
      r_evt_vec   <= {IN_W{1'b0}};
      r_overrun   <= 1'b0;
      r_evt_cnt   <= {EVT_CNT_W{1'b0}};
    end else begin
      if (w_chg) begin
        r_evt_vec   <= w_new_vec;
        r_evt_valid <= 1'b1;
      end else if (w_accept) begin
        r_evt_valid <= 1'b0;
      end
      if (w_ovr_set) begin
        r_overrun <= 1'b1;
      end else if (clr_overrun_i) begin
        r_overrun <= 1'b0;
      end
      if (w_accept) begin
        r_evt_cnt <= r_evt_cnt + EVT_CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_tt3_input_conditioner.sv
// Scenario bench for tt3_input_conditioner (DEBOUNCE_CYCLES=4): accepted events are checked
// against a queue of expected vectors, timing and flags are checked inline per scenario.
module tb_tt3_input_conditioner;
  import tt3_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in1 = 1'b0;
  logic        in2 = 1'b0;
  logic        in3 = 1'b0;
  logic        clr = 1'b0;
  tt3_vec_t    vec;
  logic        overrun;
  logic [15:0] evt_cnt;

  int          total = 0;
  int          bad = 0;
  tt3_vec_t    exp_q[$];
  tt3_vec_t    exp_v;
  bit          watch_no_valid = 1'b0;

  tt3_input_conditioner_if evt_if ();

  tt3_input_conditioner #(
    .DEBOUNCE_CYCLES (4),
    .CNT_W           (3),
    .EVT_CNT_W       (16)
  ) u_dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in1_i         (in1),
    .in2_i         (in2),
    .in3_i         (in3),
    .vec_o         (vec),
    .evt_if        (evt_if),
    .overrun_o     (overrun),
    .clr_overrun_i (clr),
    .evt_cnt_o     (evt_cnt)
  );

  always #5 clk = ~clk;

  // scoreboard: every handshake seen at the falling edge must match the oldest expected vector
  always @(negedge clk) begin
    if (rst_n && evt_if.evt_valid_o && evt_if.evt_ready_i) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL evt_unexpected got=%b expected=none", evt_if.evt_vec_o);
      end else begin
        exp_v = exp_q.pop_front();
        if (evt_if.evt_vec_o !== exp_v) begin
          bad++;
          $display("FAIL evt_vec got=%b expected=%b", evt_if.evt_vec_o, exp_v);
        end
      end
    end
    if (watch_no_valid) begin
      total++;
      if (evt_if.evt_valid_o !== 1'b0) begin
        bad++;
        $display("FAIL no_event got valid=%b expected=0", evt_if.evt_valid_o);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in1 = 1'b0; in2 = 1'b0; in3 = 1'b0; clr = 1'b0;
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    in1 = 1'b1; in2 = 1'b1; in3 = 1'b1;
    evt_if.evt_ready_i = 1'b0;
    rst_n = 1'b0;
    step(3);
    total++;
    if ({vec, evt_if.evt_valid_o, overrun} !== 5'b000_0_0 || evt_cnt !== 16'd0) begin
      bad++;
      $display("FAIL reset_state got vec=%b v=%b ovr=%b cnt=%0d expected 000/0/0/0",
               vec, evt_if.evt_valid_o, overrun, evt_cnt);
    end
    in1 = 1'b0; in2 = 1'b0; in3 = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(8);
    total++;
    if (vec !== 3'b000 || evt_if.evt_valid_o !== 1'b0) begin
      bad++;
      $display("FAIL reset_quiet got vec=%b v=%b expected 000/0", vec, evt_if.evt_valid_o);
    end
  endtask

  task automatic test_glitch();
    watch_no_valid = 1'b1;
    in2 = 1'b1;
    step(3);
    in2 = 1'b0;
    step(10);
    watch_no_valid = 1'b0;
    total++;
    if (vec !== 3'b000) begin
      bad++;
      $display("FAIL glitch_vec got=%b expected=000", vec);
    end
  endtask

  task automatic test_single();
    evt_if.evt_ready_i = 1'b1;
    in3 = 1'b1;
    exp_q.push_back(3'b001);
    for (int i = 1; i <= 5; i++) begin
      step(1);
      total++;
      if (vec !== 3'b000 || evt_if.evt_valid_o !== 1'b0) begin
        bad++;
        $display("FAIL single_early edge=%0d got vec=%b v=%b expected 000/0",
                 i, vec, evt_if.evt_valid_o);
      end
    end
    step(1);
    total++;
    if (vec !== 3'b001 || evt_if.evt_valid_o !== 1'b1 || evt_if.evt_vec_o !== 3'b001) begin
      bad++;
      $display("FAIL single_edge6 got vec=%b v=%b evt=%b expected 001/1/001",
               vec, evt_if.evt_valid_o, evt_if.evt_vec_o);
    end
    step(1);
    total++;
    if (evt_if.evt_valid_o !== 1'b0 || evt_cnt !== 16'd1 || overrun !== 1'b0) begin
      bad++;
      $display("FAIL single_accept got v=%b cnt=%0d ovr=%b expected 0/1/0",
               evt_if.evt_valid_o, evt_cnt, overrun);
    end
  endtask

  task automatic test_overrun();
    evt_if.evt_ready_i = 1'b0;
    do_reset();
    total++;
    if (evt_cnt !== 16'd0) begin
      bad++;
      $display("FAIL ovr_cnt_reset got=%0d expected=0", evt_cnt);
    end
    in3 = 1'b1;
    step(6);
    total++;
    if (evt_if.evt_valid_o !== 1'b1 || evt_if.evt_vec_o !== 3'b001 || overrun !== 1'b0) begin
      bad++;
      $display("FAIL ovr_first got v=%b evt=%b ovr=%b expected 1/001/0",
               evt_if.evt_valid_o, evt_if.evt_vec_o, overrun);
    end
    in1 = 1'b1;
    step(5);
    total++;
    if (evt_if.evt_vec_o !== 3'b001 || overrun !== 1'b0) begin
      bad++;
      $display("FAIL ovr_hold got evt=%b ovr=%b expected 001/0", evt_if.evt_vec_o, overrun);
    end
    step(1);
    total++;
    if (evt_if.evt_vec_o !== 3'b101 || overrun !== 1'b1 || vec !== 3'b101) begin
      bad++;
      $display("FAIL ovr_latest got evt=%b ovr=%b vec=%b expected 101/1/101",
               evt_if.evt_vec_o, overrun, vec);
    end
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    total++;
    if (overrun !== 1'b0 || evt_if.evt_valid_o !== 1'b1 || evt_if.evt_vec_o !== 3'b101) begin
      bad++;
      $display("FAIL ovr_clear got ovr=%b v=%b evt=%b expected 0/1/101",
               overrun, evt_if.evt_valid_o, evt_if.evt_vec_o);
    end
    in2 = 1'b1;
    step(5);
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    total++;
    if (overrun !== 1'b1 || evt_if.evt_vec_o !== 3'b111 || vec !== 3'b111) begin
      bad++;
      $display("FAIL ovr_set_wins got ovr=%b evt=%b vec=%b expected 1/111/111",
               overrun, evt_if.evt_vec_o, vec);
    end
    exp_q.push_back(3'b111);
    evt_if.evt_ready_i = 1'b1;
    step(1);
    total++;
    if (evt_if.evt_valid_o !== 1'b0 || evt_cnt !== 16'd1) begin
      bad++;
      $display("FAIL ovr_drain got v=%b cnt=%0d expected 0/1", evt_if.evt_valid_o, evt_cnt);
    end
  endtask

  task automatic test_simultaneous();
    evt_if.evt_ready_i = 1'b1;
    do_reset();
    in1 = 1'b1;
    in2 = 1'b1;
    exp_q.push_back(3'b110);
    step(6);
    total++;
    if (vec !== 3'b110 || evt_if.evt_valid_o !== 1'b1 || evt_if.evt_vec_o !== 3'b110) begin
      bad++;
      $display("FAIL simul_event got vec=%b v=%b evt=%b expected 110/1/110",
               vec, evt_if.evt_valid_o, evt_if.evt_vec_o);
    end
    step(1);
    watch_no_valid = 1'b1;
    step(8);
    watch_no_valid = 1'b0;
    total++;
    if (evt_cnt !== 16'd1) begin
      bad++;
      $display("FAIL simul_count got=%0d expected=1", evt_cnt);
    end
  endtask

  task automatic test_back_to_back();
    evt_if.evt_ready_i = 1'b1;
    in3 = 1'b1;
    step(1);
    in1 = 1'b0;
    exp_q.push_back(3'b111);
    exp_q.push_back(3'b011);
    step(5);
    total++;
    if (evt_if.evt_valid_o !== 1'b1 || evt_if.evt_vec_o !== 3'b111) begin
      bad++;
      $display("FAIL b2b_first got v=%b evt=%b expected 1/111", evt_if.evt_valid_o, evt_if.evt_vec_o);
    end
    step(1);
    total++;
    if (evt_if.evt_valid_o !== 1'b1 || evt_if.evt_vec_o !== 3'b011 || overrun !== 1'b0 ||
        evt_cnt !== 16'd2) begin
      bad++;
      $display("FAIL b2b_second got v=%b evt=%b ovr=%b cnt=%0d expected 1/011/0/2",
               evt_if.evt_valid_o, evt_if.evt_vec_o, overrun, evt_cnt);
    end
    step(1);
    total++;
    if (evt_if.evt_valid_o !== 1'b0 || evt_cnt !== 16'd3 || vec !== 3'b011) begin
      bad++;
      $display("FAIL b2b_drain got v=%b cnt=%0d vec=%b expected 0/3/011",
               evt_if.evt_valid_o, evt_cnt, vec);
    end
  endtask

  task automatic test_reset_mid();
    evt_if.evt_ready_i = 1'b0;
    do_reset();
    in3 = 1'b1;
    step(6);
    total++;
    if (evt_if.evt_valid_o !== 1'b1) begin
      bad++;
      $display("FAIL mid_pending got v=%b expected=1", evt_if.evt_valid_o);
    end
    in1 = 1'b1;
    step(2);
    rst_n = 1'b0;
    in1 = 1'b0;
    in3 = 1'b0;
    step(1);
    total++;
    if ({vec, evt_if.evt_valid_o, overrun} !== 5'b000_0_0 || evt_cnt !== 16'd0) begin
      bad++;
      $display("FAIL mid_reset got vec=%b v=%b ovr=%b cnt=%0d expected 000/0/0/0",
               vec, evt_if.evt_valid_o, overrun, evt_cnt);
    end
    step(1);
    rst_n = 1'b1;
    watch_no_valid = 1'b1;
    step(12);
    watch_no_valid = 1'b0;
    total++;
    if (vec !== 3'b000) begin
      bad++;
      $display("FAIL mid_after got vec=%b expected=000", vec);
    end
  endtask

  initial begin
    evt_if.evt_ready_i = 1'b0;
    test_reset();
    test_glitch();
    test_single();
    test_overrun();
    test_simultaneous();
    test_back_to_back();
    test_reset_mid();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL evt_missing got=%0d outstanding expected=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
